// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake; ALU_FAST_SHIFT_EN selects barrel shifts
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] comb_res;
  logic [XLEN-1:0] res_d;
  logic            load_res;

  assign shamt = op_b[SHW-1:0];

`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  logic [XLEN-1:0] work;
  logic [XLEN-1:0] work_step;
  logic [SHW-1:0]  cnt;
  logic [1:0]      sh_kind;
  logic            is_shift;
  logic            load_sh;

  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

  // One-bit step of the iterative shifter; SRA replicates the current MSB
  always_comb begin
    work_step = {1'b0, work[XLEN-1:1]};
    case (sh_kind)
      K_SLL:   work_step = {work[XLEN-2:0], 1'b0};
      K_SRA:   work_step = {work[XLEN-1], work[XLEN-1:1]};
      default: work_step = {1'b0, work[XLEN-1:1]};
    endcase
  end
`endif

  // Single-cycle datapath for everything except the iterative shifts
  always_comb begin
    comb_res = '0;
    case (alu_ctrl)
      OP_ADD:  comb_res = op_a + op_b;
      OP_SUB:  comb_res = op_a - op_b;
      OP_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: comb_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  comb_res = op_a ^ op_b;
      OP_OR:   comb_res = op_a | op_b;
      OP_AND:  comb_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  comb_res = op_a << shamt;
      OP_SRL:  comb_res = op_a >> shamt;
      OP_SRA:  comb_res = $signed(op_a) >>> shamt;
`endif
      default: comb_res = '0;
    endcase
  end

  // Next-state, handshake outputs and datapath load strobes
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load_res  = 1'b0;
    res_d     = comb_res;
`ifndef ALU_FAST_SHIFT_EN
    load_sh   = 1'b0;
`endif
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = S_IDLE;
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == SHW'(1)) begin
          state_nxt = S_DONE;
          load_res  = 1'b1;
          res_d     = work_step;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    // A new op overrides the DONE->IDLE exit so back-to-back issue works
    if (in_valid && in_ready) begin
`ifndef ALU_FAST_SHIFT_EN
      load_sh = is_shift;
      if (is_shift && (shamt != '0)) begin
        state_nxt = S_SHIFT;
      end else begin
        state_nxt = S_DONE;
        load_res  = 1'b1;
        res_d     = is_shift ? op_a : comb_res;
      end
`else
      state_nxt = S_DONE;
      load_res  = 1'b1;
      res_d     = comb_res;
`endif
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Result and zero flag, stable while waiting for out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (load_res) begin
      result <= res_d;
      zero   <= (res_d == '0);
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  // Working register and down-counter of the iterative shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      cnt     <= '0;
      sh_kind <= K_SLL;
    end else if (load_sh) begin
      work    <= op_a;
      cnt     <= shamt;
      sh_kind <= (alu_ctrl == OP_SLL) ? K_SLL : ((alu_ctrl == OP_SRL) ? K_SRL : K_SRA);
    end else if (state == S_SHIFT) begin
      work <= work_step;
      cnt  <= cnt - SHW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit (honours ALU_FAST_SHIFT_EN)
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the op table
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] r;
    int          t;
    bit          sh;
  } exp_t;
  exp_t q[$];

  // Cycle-by-cycle scoreboard: timing rules predict valid/busy/ready, ref_alu predicts data
  always @(negedge clk) begin
    bit   ev;
    bit   eb;
    bit   er;
    bit   is_sh;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_zero", {31'd0, zero}, 32'd1);
      chk("rst_result", result, 32'd0);
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].t);
      eb = (q.size() > 0) && q[0].sh && (cyc < q[0].t);
      er = (q.size() == 0) || (ev && out_ready);
      chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("cmp_busy", {31'd0, busy}, {31'd0, eb});
      chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, er});
      if (ev) begin
        chk("cmp_result", result, q[0].r);
        chk("cmp_zero", {31'd0, zero}, {31'd0, (q[0].r == 32'd0)});
      end
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && er) begin
        is_sh = !FAST && (alu_ctrl == 4'd2 || alu_ctrl == 4'd6 || alu_ctrl == 4'd7);
        e.r  = ref_alu(alu_ctrl, op_a, op_b);
        e.t  = cyc + 1 + (is_sh ? int'(op_b[4:0]) : 0);
        e.sh = is_sh && (op_b[4:0] != 5'd0);
        q.push_back(e);
      end
    end
  end

  task automatic scramble_inputs();
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 4'($urandom_range(0, 15));
  endtask

  // Issue one op from idle with out_ready high; check literal result, latency and busy count
  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int lat, input int nbusy);
    int n;
    int nb;
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    n  = 1;
    nb = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_busy_cycles"}, nb, nbusy);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bb_a [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
  logic [31:0] bb_b [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'hFFFFFFFF, 32'h11111111, 32'h80000000};
  logic [31:0] bb_s [8] = '{32'd2, 32'd4, 32'd6, 32'd8, 32'h80000000, 32'hFFFFFFFE, 32'h23456789, 32'd0};

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1, 0);
    run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 0);
    run_op("slt", 4'd3, 32'h80000000, 32'd1, 32'd1, 1, 0);
    run_op("sltu", 4'd4, 32'h80000000, 32'd1, 32'd0, 1, 0);
    run_op("illegal_c", 4'hC, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1, 0);
    run_op("illegal_f", 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1, 0);
    run_op("or", 4'd8, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1, 0);
    run_op("and", 4'd9, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1, 0);
    run_op("sra31", 4'd7, 32'h80000000, 32'd31, 32'hFFFFFFFF, FAST ? 1 : 32, FAST ? 0 : 31);
    run_op("srl31", 4'd6, 32'h80000000, 32'd31, 32'h00000001, FAST ? 1 : 32, FAST ? 0 : 31);
    run_op("sll0_hi_ignored", 4'd2, 32'h00001234, 32'hFFFFFFE0, 32'h00001234, 1, 0);
    run_op("sll4", 4'd2, 32'h00000001, 32'd4, 32'h00000010, FAST ? 1 : 5, FAST ? 0 : 4);
    run_op("sra3_pos", 4'd7, 32'h40000000, 32'd3, 32'h08000000, FAST ? 1 : 4, FAST ? 0 : 3);

    // Back-pressure on an XOR result
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'd5;
    op_a      = 32'hF0F0F0F0;
    op_b      = 32'h0FF00FF0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", result, 32'hFF00FF00);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_drop", {31'd0, out_valid}, 32'd0);

    // Eight back-to-back ADDs
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      alu_ctrl = 4'd0;
      op_a     = bb_a[i];
      op_b     = bb_b[i];
      @(posedge clk);
      #1;
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_result", result, bb_s[i]);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of SLL by 20
    in_valid = 1'b1;
    alu_ctrl = 4'd2;
    op_a     = 32'd1;
    op_b     = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    repeat (9) @(posedge clk);
    #3;
    chk("pre_reset_busy", {31'd0, busy}, FAST ? 32'd0 : 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_zero", {31'd0, zero}, 32'd1);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("post_reset_no_valid", seen, 0);

    run_op("after_reset_add", 4'd0, 32'd100, 32'd23, 32'd123, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
